// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants for the sync generator and colour stage.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // 640x480@60 uses negative-going sync pulses
    localparam logic VGA_SYNC_POL = 1'b0;

    function automatic logic in_window(logic [CNT_W-1:0] v, int lo, int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-clock divider: one-cycle pix_tick every CLK_DIV cycles of clk_100.
module vga_pix_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_100,
    input  logic rst,
    output logic pix_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

    logic [DW-1:0] div_cnt;

    // pix_tick is registered one count early so it is high while div_cnt sits at its last value
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            pix_tick <= (div_cnt == DIV_PRE);
        end
    end

endmodule

// File: rtl/vga_hvsync_gen.sv
// VGA raster timing generator: position counters, sync pulses and line/frame strobes.
// Define HVSYNC_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_hvsync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = VGA_CLK_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic             clk_100,
    input  logic             rst,
    output logic             pix_tick,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count,
    output logic             hsync,
    output logic             vsync,
    output logic             active_pixel,
    output logic             line_start,
    output logic             frame_start
`ifdef HVSYNC_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

    logic             x_wrap;
    logic             y_wrap;
    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk_100  (clk_100),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    always_comb begin
        x_wrap = pix_tick && (x_count == X_LAST);
        y_wrap = x_wrap && (y_count == Y_LAST);
        x_nxt  = x_count;
        y_nxt  = y_count;
        if (pix_tick) begin
            x_nxt = x_wrap ? '0 : x_count + 1'b1;
        end
        if (x_wrap) begin
            y_nxt = (y_count == Y_LAST) ? '0 : y_count + 1'b1;
        end
    end

    // Decode from the next positions so sync/active stay aligned with the registered counters
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            x_count      <= X_LAST;
            y_count      <= Y_LAST;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            active_pixel <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            x_count      <= x_nxt;
            y_count      <= y_nxt;
            hsync        <= in_window(x_nxt, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync        <= in_window(y_nxt, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
            active_pixel <= (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
            line_start   <= x_wrap;
            frame_start  <= y_wrap;
        end
    end

`ifdef HVSYNC_FRAME_CNT_EN
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 8'd0;
        end else if (y_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Testbench for vga_hvsync_gen: default 640x480 instance plus a shrunken raster covering whole frames.
module tb_vga_hvsync_gen;

    localparam int D_S   = 3;
    localparam int HA_S  = 20;
    localparam int HF_S  = 3;
    localparam int HS_S  = 5;
    localparam int HB_S  = 4;
    localparam int VA_S  = 12;
    localparam int VF_S  = 2;
    localparam int VS_S  = 2;
    localparam int VB_S  = 3;
    localparam logic POL_S = 1'b1;
    localparam int HT_S  = HA_S + HF_S + HS_S + HB_S;
    localparam int VT_S  = VA_S + VF_S + VS_S + VB_S;

    logic clk_100 = 1'b0;
    logic rst     = 1'b0;

    logic       pt_d, hs_d, vs_d, ap_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
    logic       pt_s, hs_s, vs_s, ap_s, ls_s, fs_s;
    logic [9:0] x_s, y_s;
`ifdef HVSYNC_FRAME_CNT_EN
    logic [7:0] fc_d, fc_s;
`endif

    int n      = 0;
    int checks = 0;
    int errors = 0;

    int  lines_in_frame = 0;
    bit  seen_fs        = 0;
    int  hs_ticks       = 0;
    bit  seen_ls        = 0;

    always #5 clk_100 = ~clk_100;

    vga_hvsync_gen dut_def (
        .clk_100      (clk_100),
        .rst          (rst),
        .pix_tick     (pt_d),
        .x_count      (x_d),
        .y_count      (y_d),
        .hsync        (hs_d),
        .vsync        (vs_d),
        .active_pixel (ap_d),
        .line_start   (ls_d),
        .frame_start  (fs_d)
`ifdef HVSYNC_FRAME_CNT_EN
        ,
        .frame_cnt    (fc_d)
`endif
    );

    vga_hvsync_gen #(
        .CLK_DIV  (D_S),
        .H_ACTIVE (HA_S),
        .H_FP     (HF_S),
        .H_SYNC   (HS_S),
        .H_BP     (HB_S),
        .V_ACTIVE (VA_S),
        .V_FP     (VF_S),
        .V_SYNC   (VS_S),
        .V_BP     (VB_S),
        .SYNC_POL (POL_S)
    ) dut_sml (
        .clk_100      (clk_100),
        .rst          (rst),
        .pix_tick     (pt_s),
        .x_count      (x_s),
        .y_count      (y_s),
        .hsync        (hs_s),
        .vsync        (vs_s),
        .active_pixel (ap_s),
        .line_start   (ls_s),
        .frame_start  (fs_s)
`ifdef HVSYNC_FRAME_CNT_EN
        ,
        .frame_cnt    (fc_s)
`endif
    );

    // n = clk_100 edges seen since reset release; every output follows from it arithmetically
    function automatic logic [25:0] model_out(int nn, int d, int ha, int hf, int hs, int hb,
                                              int va, int vf, int vs, int vb, logic pol);
        int ht, vt, t, pos, x, y;
        logic [9:0] xv, yv;
        logic tick, ls, fs, hsy, vsy, act;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        t    = nn / d;
        pos  = (ht * vt - 1 + t) % (ht * vt);
        x    = pos % ht;
        y    = pos / ht;
        tick = ((nn + 1) % d) == 0;
        ls   = (nn >= d) && ((nn % d) == 0) && (x == 0);
        fs   = ls && (y == 0);
        hsy  = (x >= ha + hf && x < ha + hf + hs) ? pol : ~pol;
        vsy  = (y >= va + vf && y < va + vf + vs) ? pol : ~pol;
        act  = (x < ha) && (y < va);
        xv   = 10'(x);
        yv   = 10'(y);
        return {tick, xv, yv, hsy, vsy, act, ls, fs};
    endfunction

    function automatic logic [7:0] model_fcnt(int nn, int d, int ht, int vt);
        int t;
        t = nn / d;
        return (t >= 1) ? 8'(((t - 1) / (ht * vt) + 1) % 256) : 8'd0;
    endfunction

    task automatic check_output(string tag);
        logic [25:0] exp_d, exp_s, obs_d, obs_s;
        exp_d = model_out(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        exp_s = model_out(n, D_S, HA_S, HF_S, HS_S, HB_S, VA_S, VF_S, VS_S, VB_S, POL_S);
        obs_d = {pt_d, x_d, y_d, hs_d, vs_d, ap_d, ls_d, fs_d};
        obs_s = {pt_s, x_s, y_s, hs_s, vs_s, ap_s, ls_s, fs_s};
        checks++;
        assert (obs_d === exp_d) else begin
            errors++;
            $error("[TB] FAIL %s default n=%0d observed=%h expected=%h", tag, n, obs_d, exp_d);
        end
        checks++;
        assert (obs_s === exp_s) else begin
            errors++;
            $error("[TB] FAIL %s small n=%0d observed=%h expected=%h", tag, n, obs_s, exp_s);
        end
`ifdef HVSYNC_FRAME_CNT_EN
        checks++;
        assert (fc_d === model_fcnt(n, 4, 800, 525)) else begin
            errors++;
            $error("[TB] FAIL %s frame_cnt default n=%0d observed=%0d expected=%0d",
                   tag, n, fc_d, model_fcnt(n, 4, 800, 525));
        end
        checks++;
        assert (fc_s === model_fcnt(n, D_S, HT_S, VT_S)) else begin
            errors++;
            $error("[TB] FAIL %s frame_cnt small n=%0d observed=%0d expected=%0d",
                   tag, n, fc_s, model_fcnt(n, D_S, HT_S, VT_S));
        end
`endif
    endtask

    // Line and frame period checks on the small raster, counted from observed strobes
    task automatic check_periods();
        if (fs_s) begin
            if (seen_fs) begin
                checks++;
                assert (lines_in_frame === VT_S) else begin
                    errors++;
                    $error("[TB] FAIL lines_per_frame observed=%0d expected=%0d", lines_in_frame, VT_S);
                end
            end
            seen_fs        = 1;
            lines_in_frame = 0;
        end
        if (ls_s) begin
            if (seen_ls) begin
                checks++;
                assert (hs_ticks === HS_S) else begin
                    errors++;
                    $error("[TB] FAIL hsync_ticks_per_line observed=%0d expected=%0d", hs_ticks, HS_S);
                end
            end
            seen_ls  = 1;
            hs_ticks = 0;
            lines_in_frame++;
        end
        if (pt_s && hs_s === POL_S) hs_ticks++;
    endtask

    task automatic apply_stimulus(int cycles, string tag);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_100);
            if (rst) n++;
            #1;
            check_output(tag);
            if (rst) check_periods();
        end
    endtask

    task automatic release_reset();
        @(negedge clk_100);
        rst            = 1'b1;
        n              = 0;
        seen_fs        = 0;
        seen_ls        = 0;
        lines_in_frame = 0;
        hs_ticks       = 0;
        #1;
        check_output("release");
    endtask

    initial begin
        $display("[TB] vga_hvsync_gen test start");
        rst = 1'b0;
        apply_stimulus(10, "in_reset");
        release_reset();
        apply_stimulus(4000 + int'($urandom_range(0, 500)), "run0");

        for (int r = 0; r < 3; r++) begin
            #2;
            rst = 1'b0;
            n   = 0;
            #1;
            check_output("async_reset");
            apply_stimulus(int'($urandom_range(2, 8)), "held_reset");
            release_reset();
            apply_stimulus(int'($urandom_range(1500, 4500)), "run");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_hvsync_gen.md
Name: vga_hvsync_gen

Overview:
Raster timing generator for the VGA output path. It divides clk_100 into a one-cycle pixel-enable tick and runs horizontal/vertical position counters. It produces registered x_count/y_count, hsync, vsync, active_pixel and line/frame start strobes. It sits directly upstream of the pixel colour stage, which consumes the positions and drives vga_r/g/b.

Parameters:
CLK_DIV, 4, clk_100 cycles per pixel (100 MHz / 4 = 25 MHz); legal range 2..16
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, hsync pulse width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vsync pulse width, in lines
V_BP, 33, vertical back porch, in lines
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low, as required by 640x480@60)

Ports:
clk_100  in  1  100 MHz system clock
rst  in  1  asynchronous, active-low reset
pix_tick  out  1  one-cycle pixel enable
x_count  out  10  horizontal position, 0..H_TOTAL-1
y_count  out  10  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active_pixel  out  1  high when x_count < H_ACTIVE and y_count < V_ACTIVE
line_start  out  1  one-cycle strobe for the first cycle of x_count = 0
frame_start  out  1  one-cycle strobe for the first cycle of x_count = 0, y_count = 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; the 10-bit counters never exceed TOTAL-1.
- Clock and reset: one clock, clk_100; reset rst is asynchronous, active-low. All outputs come directly from flip-flops.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick is high exactly while div_cnt = CLK_DIV-1, i.e. 1 cycle in every CLK_DIV.
- Counter update, on the clk_100 edge that ends a pix_tick-high cycle:
  - x_count increments; at H_TOTAL-1 it wraps to 0.
  - On the x wrap, y_count increments; at V_TOTAL-1 it wraps to 0.
  - Counters hold on all other cycles.
- hsync = SYNC_POL while H_ACTIVE+H_FP ≤ x_count < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL while V_ACTIVE+V_FP ≤ y_count < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~SYNC_POL.
- Alignment: hsync, vsync and active_pixel are registered from the next counter values, so they are coherent with x_count/y_count in every cycle (zero relative latency).
- Strobes: line_start and frame_start are high for exactly one clk_100 cycle, the first cycle after the edge where x_count becomes 0 (frame_start additionally requires y_count becomes 0). frame_start implies line_start.
- Reset values: div_cnt = 0; x_count = H_TOTAL-1; y_count = V_TOTAL-1; pix_tick = 0; hsync = vsync = ~SYNC_POL; active_pixel = 0; line_start = frame_start = 0.
- First frame after reset: the first pix_tick falls in cycle CLK_DIV after rst deasserts. Its edge rolls the counters to (0,0), so frame_start, line_start and active_pixel are high in cycle CLK_DIV+1.
- Reset asserted mid-frame: all state returns immediately (asynchronously) to the reset values; the sequence above repeats on release.

Optional Feature:
HVSYNC_FRAME_CNT_EN
- Defined: adds output frame_cnt [7:0], reset 0. It increments by 1 (mod 256) in the same cycle frame_start asserts; intended for test patterns and blink effects.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds the 640x480@60 timing constants, derived H_TOTAL/V_TOTAL, the counter width (10) and the sync-polarity constant. The colour stage reuses the same values.
- One sub-module, vga_pix_div: parameterised CLK_DIV divider producing pix_tick. The counters, sync decode and strobes stay in vga_hvsync_gen.

Test Plan:
1. Reset release, defaults: 10 cycles of rst = 0, then release -> pix_tick first high in cycle 4; x/y become (0,0) at cycle 5 with frame_start = line_start = active_pixel = 1 and hsync = vsync = 1.
2. Line timing: run one line -> 800 pix_ticks between line_starts (3200 clk_100 cycles); hsync low exactly for x = 656..751 (96 ticks, 384 cycles); active_pixel low from x = 640.
3. Frame timing: run a full frame -> 525 line_starts between frame_starts (1,680,000 cycles); vsync low only for y = 490..491; active_pixel = 0 for all y ≥ 480.
4. Wrap corner: at x = 799, y = 524 the next tick gives (0,0); the previous tick at x = 799, y = 479 gives (0,480) with active_pixel = 0; no counter ever exceeds 799/524.
5. Mid-frame reset: assert rst at x = 300, y = 200 -> all outputs at reset values within the same cycle; after release the sequence matches scenario 1.
6. With HVSYNC_FRAME_CNT_EN: 3 frames -> frame_cnt steps 0→1→2→3, each change coincident with frame_start; force the value to 255 -> the next frame wraps it to 0.
